// File: rtl/ppu_oam_port.sv
// ppu_oam_port: PPU-side responder for the OAMADDR ($2003) and OAMDATA ($2004)
// CPU bus registers. Holds the 256x8 object attribute memory, the
// auto-incrementing OAM address and a read port for the sprite renderer.
// Bus writes commit on the clock in which the CPU phi2 falling edge is seen.
// Optional feature macro: PPU_OAM_ATTR_MASK_EN (attribute bytes, i.e. address
// bits [1:0] == 2'b10, have bits 4:2 forced to zero when stored).
module ppu_oam_port #(
  parameter logic [7:0]  OAM_ADDR_RESET = 8'h00,
  parameter int unsigned DECODE_MIRROR  = 1
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_addr,
  input  logic [7:0]  I_wr_data,
  input  logic        I_rdwr,
  input  logic        I_phy2,
  output logic [7:0]  O_rd_data,
  output logic        O_rd_valid,
  input  logic        I_rendering,
  input  logic [7:0]  I_ren_addr,
  output logic [7:0]  O_ren_data,
  output logic [7:0]  O_oamaddr
);

`ifdef PPU_OAM_ATTR_MASK_EN
  localparam bit ATTR_MASK_EN = 1'b1;
`else
  localparam bit ATTR_MASK_EN = 1'b0;
`endif

  logic [7:0] oam_q [256];

  logic [7:0] oamaddr_q,  oamaddr_d;
  logic [7:0] rd_data_q,  rd_data_d;
  logic [7:0] ren_data_q, ren_data_d;
  logic       last_phy2_q, last_phy2_d;

  logic       hit_2003;
  logic       hit_2004;
  logic       fall;
  logic       wr_commit;
  logic       oam_we;
  logic [7:0] oam_wdata;

  // Register decode: mirrored every 8 bytes across $2000-$3FFF, or exact.
  always_comb begin
    hit_2003 = 1'b0;
    hit_2004 = 1'b0;
    if (DECODE_MIRROR != 0) begin
      hit_2003 = (I_addr[15:13] == 3'b001) && (I_addr[2:0] == 3'd3);
      hit_2004 = (I_addr[15:13] == 3'b001) && (I_addr[2:0] == 3'd4);
    end else begin
      hit_2003 = (I_addr == 16'h2003);
      hit_2004 = (I_addr == 16'h2004);
    end
  end

  // Commit strobe, OAM address update, OAM write request and read ports.
  always_comb begin
    fall        = last_phy2_q & ~I_phy2;
    wr_commit   = fall & ~I_rdwr;
    last_phy2_d = I_phy2;
    oamaddr_d   = oamaddr_q;
    oam_we      = 1'b0;
    oam_wdata   = I_wr_data;
    if (ATTR_MASK_EN && (oamaddr_q[1:0] == 2'b10)) begin
      oam_wdata = I_wr_data & 8'hE3;
    end
    if (wr_commit) begin
      if (hit_2003) begin
        oamaddr_d = I_wr_data;
      end else if (hit_2004) begin
        if (I_rendering) begin
          // Glitchy rendering-time write: skip to the next sprite, no store.
          oamaddr_d = oamaddr_q + 8'd4;
        end else begin
          oam_we    = 1'b1;
          oamaddr_d = oamaddr_q + 8'd1;
        end
      end
    end
    // Both read ports sample the array before this clock's write lands.
    rd_data_d  = oam_q[oamaddr_q];
    ren_data_d = oam_q[I_ren_addr];
  end

  // Control state and registered read data, cleared asynchronously.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      oamaddr_q   <= OAM_ADDR_RESET;
      rd_data_q   <= '0;
      ren_data_q  <= '0;
      last_phy2_q <= 1'b0;
    end else begin
      oamaddr_q   <= oamaddr_d;
      rd_data_q   <= rd_data_d;
      ren_data_q  <= ren_data_d;
      last_phy2_q <= last_phy2_d;
    end
  end

  // OAM array write; contents survive reset.
  always_ff @(posedge I_clock) begin
    if (oam_we) begin
      oam_q[oamaddr_q] <= oam_wdata;
    end
  end

  assign O_rd_valid = hit_2004 & I_rdwr & I_phy2;
  assign O_rd_data  = rd_data_q;
  assign O_ren_data = ren_data_q;
  assign O_oamaddr  = oamaddr_q;

endmodule

// File: tb/tb_ppu_oam_port.sv
// tb_ppu_oam_port: directed, table-driven bench for ppu_oam_port.
module tb_ppu_oam_port;

  logic        I_clock;
  logic        I_reset;
  logic [15:0] I_addr;
  logic [7:0]  I_wr_data;
  logic        I_rdwr;
  logic        I_phy2;
  logic [7:0]  O_rd_data;
  logic        O_rd_valid;
  logic        I_rendering;
  logic [7:0]  I_ren_addr;
  logic [7:0]  O_ren_data;
  logic [7:0]  O_oamaddr;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PPU_OAM_ATTR_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rendering;
    logic [7:0]  exp_oamaddr;
  } wr_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } ren_vec_t;

  wr_vec_t  wv [12];
  ren_vec_t rv [8];

  ppu_oam_port #(
    .OAM_ADDR_RESET(8'h00),
    .DECODE_MIRROR (1)
  ) dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_addr     (I_addr),
    .I_wr_data  (I_wr_data),
    .I_rdwr     (I_rdwr),
    .I_phy2     (I_phy2),
    .O_rd_data  (O_rd_data),
    .O_rd_valid (O_rd_valid),
    .I_rendering(I_rendering),
    .I_ren_addr (I_ren_addr),
    .O_ren_data (O_ren_data),
    .O_oamaddr  (O_oamaddr)
  );

  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Value the OAM is expected to hold after storing v at address a.
  function automatic logic [7:0] stored(input logic [7:0] a, input logic [7:0] v);
    return (MASK_EN && (a[1:0] == 2'b10)) ? (v & 8'hE3) : v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %02h required %02h", name, act, exp);
    end
  endtask

  // One full phi2 period; a write commits at the posedge after phi2 drops.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic ren);
    @(negedge I_clock);
    I_addr = a; I_wr_data = d; I_rdwr = 1'b0; I_rendering = ren; I_phy2 = 1'b1;
    @(negedge I_clock);
    @(negedge I_clock);
    I_phy2 = 1'b0;
    @(negedge I_clock);
    I_rdwr = 1'b1; I_addr = 16'h0000; I_rendering = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [15:0] a, input logic exp_valid,
                          input logic [7:0] exp_data, input logic [7:0] exp_addr);
    @(negedge I_clock);
    I_addr = a; I_rdwr = 1'b1; I_phy2 = 1'b1;
    #1 check({name, "_valid_hi"}, {7'b0, O_rd_valid}, {7'b0, exp_valid});
    @(negedge I_clock);
    @(negedge I_clock);
    check({name, "_data"}, O_rd_data, exp_data);
    I_phy2 = 1'b0;
    #1 check({name, "_valid_lo"}, {7'b0, O_rd_valid}, 8'h00);
    @(negedge I_clock);
    @(negedge I_clock);
    check({name, "_oamaddr"}, O_oamaddr, exp_addr);
    I_addr = 16'h0000;
  endtask

  task automatic ren_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    @(negedge I_clock);
    I_ren_addr = a;
    @(negedge I_clock);
    check(name, O_ren_data, exp);
  endtask

  initial begin
    wv[0]  = '{16'h2003, 8'h10, 1'b0, 8'h10};
    wv[1]  = '{16'h2004, 8'hA1, 1'b0, 8'h11};
    wv[2]  = '{16'h2004, 8'hA4, 1'b0, 8'h12};
    wv[3]  = '{16'h2004, 8'hA5, 1'b0, 8'h13};
    wv[4]  = '{16'h2004, 8'hA7, 1'b0, 8'h14};
    wv[5]  = '{16'h2005, 8'h33, 1'b0, 8'h14};
    wv[6]  = '{16'h200B, 8'h18, 1'b0, 8'h18};
    wv[7]  = '{16'h2003, 8'h14, 1'b0, 8'h14};
    // rendering-time writes, applied after the DMA fill
    wv[8]  = '{16'h2003, 8'h05, 1'b0, 8'h05};
    wv[9]  = '{16'h2004, 8'h55, 1'b1, 8'h09};
    wv[10] = '{16'h2003, 8'hFD, 1'b0, 8'hFD};
    wv[11] = '{16'h2004, 8'h66, 1'b1, 8'h01};

    rv[0] = '{8'h10, stored(8'h10, 8'hA1)};
    rv[1] = '{8'h11, stored(8'h11, 8'hA4)};
    rv[2] = '{8'h12, stored(8'h12, 8'hA5)};
    rv[3] = '{8'h13, stored(8'h13, 8'hA7)};
    // DMA fill leaves oam[a] = a + 2; rendering writes must not alter it
    rv[4] = '{8'h05, stored(8'h05, 8'h07)};
    rv[5] = '{8'h09, stored(8'h09, 8'h0B)};
    rv[6] = '{8'hFD, stored(8'hFD, 8'hFF)};
    rv[7] = '{8'h01, stored(8'h01, 8'h03)};

    I_reset = 1'b1; I_addr = '0; I_wr_data = '0; I_rdwr = 1'b1; I_phy2 = 1'b0;
    I_rendering = 1'b0; I_ren_addr = '0;

    // reset state
    @(negedge I_clock);
    @(negedge I_clock);
    check("rst_oamaddr", O_oamaddr, 8'h00);
    check("rst_rd_data", O_rd_data, 8'h00);
    check("rst_ren_data", O_ren_data, 8'h00);
    check("rst_rd_valid", {7'b0, O_rd_valid}, 8'h00);
    I_reset = 1'b0;

    // setup writes and decode cases
    for (int i = 0; i < 8; i++) begin
      bus_write(wv[i].addr, wv[i].data, wv[i].rendering);
      check($sformatf("wv%0d_oamaddr", i), O_oamaddr, wv[i].exp_oamaddr);
    end
    for (int i = 0; i < 4; i++) ren_check($sformatf("rv%0d", i), rv[i].addr, rv[i].exp);

    // 256 back-to-back DMA pushes starting at 0xFE
    bus_write(16'h2003, 8'hFE, 1'b0);
    for (int n = 0; n < 256; n++) bus_write(16'h2004, n[7:0], 1'b0);
    check("dma_oamaddr", O_oamaddr, 8'hFE);
    for (int n = 0; n < 256; n++) begin
      logic [7:0] a;
      a = 8'hFE + n[7:0];
      ren_check($sformatf("dma_oam_%02h", a), a, stored(a, n[7:0]));
    end

    // rendering-time $2004 writes
    for (int i = 8; i < 12; i++) begin
      bus_write(wv[i].addr, wv[i].data, wv[i].rendering);
      check($sformatf("wv%0d_oamaddr", i), O_oamaddr, wv[i].exp_oamaddr);
    end
    for (int i = 4; i < 8; i++) ren_check($sformatf("rv%0d", i), rv[i].addr, rv[i].exp);

    // $2004 read and $2003 read
    bus_write(16'h2003, 8'h20, 1'b0);
    bus_write(16'h2004, 8'h7E, 1'b0);
    bus_write(16'h2003, 8'h20, 1'b0);
    bus_read("rd2004", 16'h2004, 1'b1, stored(8'h20, 8'h7E), 8'h20);
    bus_read("rd2003", 16'h2003, 1'b0, stored(8'h20, 8'h7E), 8'h20);

    // mirror decode and $4014 ignored
    bus_write(16'h3FFB, 8'h40, 1'b0);
    check("mirror_3ffb", O_oamaddr, 8'h40);
    bus_write(16'h4014, 8'h02, 1'b0);
    check("ignore_4014", O_oamaddr, 8'h40);

    // read-before-write on the renderer port at oamaddr 0x40 (old value 0x42)
    @(negedge I_clock);
    I_addr = 16'h2004; I_wr_data = 8'hC3; I_rdwr = 1'b0; I_phy2 = 1'b1; I_ren_addr = 8'h40;
    @(negedge I_clock);
    @(negedge I_clock);
    I_phy2 = 1'b0;
    @(negedge I_clock);
    check("rbw_old", O_ren_data, stored(8'h40, 8'h42));
    I_rdwr = 1'b1; I_addr = 16'h0000;
    @(negedge I_clock);
    check("rbw_new", O_ren_data, stored(8'h40, 8'hC3));

    // reset in the middle of an uncommitted write
    bus_write(16'h2003, 8'h30, 1'b0);
    bus_write(16'h2004, 8'h99, 1'b0);
    check("pre_rst_oamaddr", O_oamaddr, 8'h31);
    @(negedge I_clock);
    I_addr = 16'h2004; I_wr_data = 8'h77; I_rdwr = 1'b0; I_phy2 = 1'b1;
    @(negedge I_clock);
    #2 I_reset = 1'b1;
    #1 check("midrst_oamaddr", O_oamaddr, 8'h00);
    @(negedge I_clock);
    I_phy2 = 1'b0;
    @(negedge I_clock);
    I_reset = 1'b0;
    I_rdwr = 1'b1; I_addr = 16'h0000;
    @(negedge I_clock);
    @(negedge I_clock);
    check("postrst_oamaddr", O_oamaddr, 8'h00);
    ren_check("postrst_oam30", 8'h30, stored(8'h30, 8'h99));
    ren_check("postrst_oam31", 8'h31, stored(8'h31, 8'h33));
    ren_check("postrst_oam00", 8'h00, stored(8'h00, 8'h02));

    // attribute byte masking
    bus_write(16'h2003, 8'h02, 1'b0);
    bus_write(16'h2004, 8'hFF, 1'b0);
    ren_check("attr_ren", 8'h02, MASK_EN ? 8'hE3 : 8'hFF);
    bus_write(16'h2003, 8'h02, 1'b0);
    bus_read("attr_rd", 16'h2004, 1'b1, MASK_EN ? 8'hE3 : 8'hFF, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
